// File: rtl/dpa_alu_scheduler.sv
// Round-robin front end for one shared masked DPA ALU: grants one requester,
// fetches fresh randomness, runs the op (with timeout abort) and returns the result.
module dpa_alu_scheduler #(
    parameter int WIDTH   = 32,
    parameter int SHARES  = 3,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [NREQ-1:0]               req_valid_i,
    output logic [NREQ-1:0]               req_ready_o,
    input  logic [NREQ*8-1:0]             req_op_i,
    input  logic [NREQ*WIDTH*SHARES-1:0]  req_a_i,
    input  logic [NREQ*WIDTH*SHARES-1:0]  req_b_i,
    input  logic [NREQ-1:0]               req_cin_i,
    input  logic                          rng_valid_i,
    output logic                          rng_ready_o,
    input  logic [3*WIDTH*SHARES-1:0]     rng_data_i,
    output logic [WIDTH*SHARES-1:0]       alu_reg_1_o,
    output logic [WIDTH*SHARES-1:0]       alu_reg_2_o,
    output logic [WIDTH*SHARES-1:0]       alu_r_1_o,
    output logic [WIDTH*SHARES-1:0]       alu_r_2_o,
    output logic [WIDTH*SHARES-1:0]       alu_r_3_o,
    output logic                          alu_carry_in_o,
    output logic                          alu_enable_o,
    output logic [7:0]                    alu_sel_o,
    input  logic [WIDTH*SHARES-1:0]       alu_out_i,
    input  logic                          alu_carry_out_i,
    input  logic                          alu_ready_i,
    output logic [NREQ-1:0]               rsp_valid_o,
    input  logic [NREQ-1:0]               rsp_ready_i,
    output logic [WIDTH*SHARES-1:0]       rsp_data_o,
    output logic                          rsp_carry_o,
    output logic                          rsp_err_o
);
    localparam int DW = WIDTH * SHARES;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, RAND, RUN, GAP, RESP} state_t;
    state_t state_q, state_d;

    logic [IW-1:0] rr_q, grant_q, gnt_idx;
    logic          gnt_vld;
    int            cand;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] reg_1_q, reg_2_q, r_1_q, r_2_q, r_3_q, rsp_data_q;
    logic [7:0]    sel_q;
    logic          cin_q, rsp_carry_q, rsp_err_q;
    logic          timeout_hit;

    // Scan requesters starting at the rr pointer; first pending one wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!gnt_vld && req_valid_i[IW'(cand)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_vld) state_d = RAND;
            RAND:    if (rng_valid_i) state_d = RUN;
            RUN:     if (alu_ready_i || timeout_hit) state_d = GAP;
            GAP:     state_d = RESP;
            RESP:    if (rsp_ready_i[grant_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q        <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            reg_1_q     <= '0;
            reg_2_q     <= '0;
            r_1_q       <= '0;
            r_2_q       <= '0;
            r_3_q       <= '0;
            sel_q       <= '0;
            cin_q       <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q <= (state_q == RUN) ? cnt_q + 1'b1 : '0;
            case (state_q)
                IDLE: if (gnt_vld) begin
                    grant_q <= gnt_idx;
                    rr_q    <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    reg_1_q <= req_a_i[int'(gnt_idx)*DW +: DW];
                    reg_2_q <= req_b_i[int'(gnt_idx)*DW +: DW];
                    sel_q   <= req_op_i[int'(gnt_idx)*8 +: 8];
                    cin_q   <= req_cin_i[gnt_idx];
                end
                RAND: if (rng_valid_i) begin
                    r_1_q <= rng_data_i[0 +: DW];
                    r_2_q <= rng_data_i[DW +: DW];
                    r_3_q <= rng_data_i[2*DW +: DW];
                end
                RUN: if (alu_ready_i) begin
                    rsp_data_q  <= alu_out_i;
                    rsp_carry_q <= alu_carry_out_i;
                    rsp_err_q   <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data_q  <= '0;
                    rsp_carry_q <= 1'b0;
                    rsp_err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Handshake strobes decode straight from state so they never lead or lag it.
    assign req_ready_o    = (state_q == IDLE && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;
    assign rng_ready_o    = (state_q == RAND);
    assign alu_enable_o   = (state_q == RUN);
    assign rsp_valid_o    = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;
    assign alu_reg_1_o    = reg_1_q;
    assign alu_reg_2_o    = reg_2_q;
    assign alu_r_1_o      = r_1_q;
    assign alu_r_2_o      = r_2_q;
    assign alu_r_3_o      = r_3_q;
    assign alu_sel_o      = sel_q;
    assign alu_carry_in_o = cin_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_carry_o    = rsp_carry_q;
    assign rsp_err_o      = rsp_err_q;
endmodule

// File: tb/tb_dpa_alu_scheduler.sv
// Directed bench for dpa_alu_scheduler with a Boolean-masked adder ALU model.
module tb_dpa_alu_scheduler;
    localparam int NREQ = 2;
    localparam int DW   = 96;
    localparam int TO   = 64;

    logic clk, rst;
    logic [NREQ-1:0] req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
    logic [NREQ*8-1:0] req_op;
    logic [NREQ*DW-1:0] req_a, req_b;
    logic rng_valid, rng_ready;
    logic [3*DW-1:0] rng_data;
    logic [DW-1:0] alu_reg_1, alu_reg_2, alu_r_1, alu_r_2, alu_r_3, alu_out, rsp_data;
    logic alu_carry_in, alu_enable, alu_carry_out, alu_ready, rsp_carry, rsp_err;
    logic [7:0] alu_sel;

    int checks = 0, errors = 0;
    int alu_lat = 2, alu_cnt = 0;
    bit alu_never = 0;
    int stab_err = 0, gap_err = 0, en_run = 0, last_run = 0;
    logic prev_en = 0, prev_done = 0;
    logic [5*DW+8:0] prev_bus = '0;

    dpa_alu_scheduler #(.WIDTH(32), .SHARES(3), .NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clock_i(clk), .reset_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin),
        .rng_valid_i(rng_valid), .rng_ready_o(rng_ready), .rng_data_i(rng_data),
        .alu_reg_1_o(alu_reg_1), .alu_reg_2_o(alu_reg_2),
        .alu_r_1_o(alu_r_1), .alu_r_2_o(alu_r_2), .alu_r_3_o(alu_r_3),
        .alu_carry_in_o(alu_carry_in), .alu_enable_o(alu_enable), .alu_sel_o(alu_sel),
        .alu_out_i(alu_out), .alu_carry_out_i(alu_carry_out), .alu_ready_i(alu_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_carry_o(rsp_carry), .rsp_err_o(rsp_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mask(input logic [31:0] v, input logic [31:0] m1, input logic [31:0] m2);
        return {v ^ m1 ^ m2, m2, m1};
    endfunction
    function automatic logic [31:0] rc(input logic [DW-1:0] x);
        return x[31:0] ^ x[63:32] ^ x[95:64];
    endfunction

    // ALU model: XOR-masked add, ready after alu_lat extra enabled cycles.
    logic [32:0] sum;
    always_comb begin
        sum = {1'b0, rc(alu_reg_1)} + {1'b0, rc(alu_reg_2)} + {32'd0, alu_carry_in};
        alu_out = {sum[31:0] ^ alu_r_1[31:0] ^ alu_r_1[63:32], alu_r_1[63:32], alu_r_1[31:0]};
        alu_carry_out = sum[32];
    end
    assign alu_ready = alu_enable && !alu_never && (alu_cnt == alu_lat);
    always @(posedge clk) alu_cnt <= alu_enable ? alu_cnt + 1 : 0;

    always @(posedge clk) begin
        if (alu_enable && prev_en &&
            {alu_reg_1, alu_reg_2, alu_r_1, alu_r_2, alu_r_3, alu_sel, alu_carry_in} != prev_bus)
            stab_err <= stab_err + 1;
        if (prev_done && alu_enable) gap_err <= gap_err + 1;
        if (!alu_enable && prev_en) last_run <= en_run;
        en_run    <= alu_enable ? en_run + 1 : 0;
        prev_en   <= alu_enable;
        prev_done <= alu_enable & alu_ready;
        prev_bus  <= {alu_reg_1, alu_reg_2, alu_r_1, alu_r_2, alu_r_3, alu_sel, alu_carry_in};
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] op, input logic cin);
        req_a[i*DW +: DW] = mask(a, 32'hA5A5_0F0F ^ i, 32'h3C3C_1234);
        req_b[i*DW +: DW] = mask(b, 32'h0BAD_F00D, 32'h7777_0001 ^ i);
        req_op[i*8 +: 8]  = op;
        req_cin[i]        = cin;
    endtask

    task automatic wait_grant(output int g, output bit ok);
        ok = 0; g = -1;
        #1;
        for (int c = 0; c < 50; c++) begin
            if (req_ready != 0) begin
                ok = 1;
                g = req_ready[1] ? 1 : 0;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic wait_rsp(input int bound, output int lat, output bit ok);
        lat = 1;
        while (lat < bound && rsp_valid == 0) begin
            step();
            lat++;
        end
        ok = (rsp_valid != 0);
    endtask

    task automatic ack(input int g);
        rsp_ready[g] = 1'b1;
        step();
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        rst = 1; step();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if (rng_ready !== 1'b0) begin errors++; $display("FAIL reset_rng_ready got %b want 0", rng_ready); end
        checks++; if (alu_enable !== 1'b0) begin errors++; $display("FAIL reset_alu_enable got %b want 0", alu_enable); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        checks++; if (rsp_data !== '0 || rsp_err !== 1'b0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b/%b want 0", rsp_data, rsp_err, rsp_carry); end
        checks++; if (alu_reg_1 !== '0 || alu_r_1 !== '0 || alu_sel !== 8'h00) begin errors++; $display("FAIL reset_alu_drive got %h %h %h want 0", alu_reg_1, alu_r_1, alu_sel); end
        rst = 0; step();
    endtask

    task automatic test_single();
        int g, lat; bit ok;
        alu_lat = 2;
        set_req(0, 32'd5, 32'hFFFF_FFFD, 8'h00, 1'b0);
        req_valid = 2'b01;
        wait_grant(g, ok);
        req_valid = 2'b00;
        checks++; if (!ok || g != 0) begin errors++; $display("FAIL single_grant got %0d ok %0d want 0", g, ok); end
        wait_rsp(100, lat, ok);
        checks++; if (!ok || lat != 6) begin errors++; $display("FAIL single_latency got %0d want 6", lat); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b want 01", rsp_valid); end
        checks++; if (rc(rsp_data) !== 32'd2) begin errors++; $display("FAIL single_data got %h want 2", rc(rsp_data)); end
        checks++; if (rsp_carry !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_flags got c%b e%b want c1 e0", rsp_carry, rsp_err); end
        checks++; if (alu_sel !== 8'h00 || alu_r_1 !== rng_data[DW-1:0]) begin errors++; $display("FAIL single_drive got sel %h r1 %h", alu_sel, alu_r_1); end
        ack(0);
        step();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_clear got %b want 00", rsp_valid); end
    endtask

    task automatic test_rr();
        int g, lat; bit ok;
        rst = 1; step(); rst = 0; step();
        set_req(0, 32'd100, 32'd23, 8'h3C, 1'b0);
        set_req(1, 32'd7, 32'd8, 8'hA5, 1'b1);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, ok);
            checks++; if (!ok || g != (k % 2)) begin errors++; $display("FAIL rr_grant%0d got %0d want %0d", k, g, k % 2); end
            wait_rsp(100, lat, ok);
            checks++; if (!ok || rc(rsp_data) !== ((k % 2) ? 32'd16 : 32'd123)) begin errors++; $display("FAIL rr_data%0d got %0d want %0d", k, rc(rsp_data), (k % 2) ? 16 : 123); end
            checks++; if (alu_sel !== ((k % 2) ? 8'hA5 : 8'h3C)) begin errors++; $display("FAIL rr_sel%0d got %h", k, alu_sel); end
            ack((k % 2));
        end
        req_valid = 2'b00;
    endtask

    task automatic test_rng_stall();
        int g, lat, viol; bit ok;
        viol = 0;
        rng_valid = 0;
        rng_data = {96'h333333333333333333333333, 96'h222222222222222222222222, 96'h1111111111111111DEADBEEF};
        set_req(0, 32'h0000_FFFF, 32'h0000_0001, 8'h01, 1'b0);
        req_valid = 2'b01;
        wait_grant(g, ok);
        req_valid = 2'b00;
        for (int c = 0; c < 10; c++) begin
            if (alu_enable !== 1'b0 || rng_ready !== 1'b1) viol++;
            step();
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL rng_stall got %0d bad cycles want 0", viol); end
        rng_valid = 1;
        wait_rsp(100, lat, ok);
        checks++; if (!ok || rc(rsp_data) !== 32'h0001_0000) begin errors++; $display("FAIL rng_data got %h want 00010000", rc(rsp_data)); end
        checks++; if (alu_r_1 !== 96'h1111111111111111DEADBEEF || alu_r_3 !== 96'h333333333333333333333333) begin errors++; $display("FAIL rng_slices got r1 %h r3 %h", alu_r_1, alu_r_3); end
        ack(0);
    endtask

    task automatic test_timeout();
        int g, lat; bit ok;
        alu_never = 1;
        set_req(1, 32'd9, 32'd9, 8'h00, 1'b0);
        req_valid = 2'b10;
        wait_grant(g, ok);
        req_valid = 2'b00;
        wait_rsp(300, lat, ok);
        checks++; if (!ok || rsp_valid !== 2'b10) begin errors++; $display("FAIL to_rsp_valid got %b want 10", rsp_valid); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", rsp_err); end
        checks++; if (rsp_data !== '0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL to_data got %h c%b want 0", rsp_data, rsp_carry); end
        checks++; if (last_run != TO) begin errors++; $display("FAIL to_enable_cycles got %0d want %0d", last_run, TO); end
        ack(1);
        alu_never = 0;
    endtask

    task automatic test_reset_mid();
        int g, lat, c; bit ok;
        alu_lat = 20;
        set_req(1, 32'd40, 32'd2, 8'h00, 1'b0);
        req_valid = 2'b10;
        wait_grant(g, ok);
        c = 0;
        while (alu_enable !== 1'b1 && c < 20) begin step(); c++; end
        checks++; if (alu_enable !== 1'b1) begin errors++; $display("FAIL mid_run_reached got %b want 1", alu_enable); end
        step(); step();
        rst = 1; #1;
        checks++; if (alu_enable !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_reset got en %b rv %b want 0 00", alu_enable, rsp_valid); end
        checks++; if (rng_ready !== 1'b0 || alu_reg_1 !== '0) begin errors++; $display("FAIL mid_reset_drive got %b %h want 0", rng_ready, alu_reg_1); end
        step();
        rst = 0;
        alu_lat = 2;
        wait_grant(g, ok);
        req_valid = 2'b00;
        checks++; if (!ok || g != 1) begin errors++; $display("FAIL mid_regrant got %0d want 1", g); end
        wait_rsp(100, lat, ok);
        checks++; if (!ok || rc(rsp_data) !== 32'd42 || rsp_err !== 1'b0) begin errors++; $display("FAIL mid_data got %0d e%b want 42 e0", rc(rsp_data), rsp_err); end
        checks++; if (lat != 6) begin errors++; $display("FAIL mid_latency got %0d want 6", lat); end
        ack(1);
    endtask

    task automatic test_back_to_back();
        int g, lat, viol; bit ok;
        logic [DW-1:0] snap;
        viol = 0;
        alu_lat = 0;
        set_req(0, 32'h1234_5678, 32'h1111_1111, 8'h00, 1'b0);
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 8'h00, 1'b0);
        req_valid = 2'b11;
        wait_grant(g, ok);
        checks++; if (!ok || g != 0) begin errors++; $display("FAIL b2b_grant0 got %0d want 0", g); end
        wait_rsp(100, lat, ok);
        snap = rsp_data;
        checks++; if (!ok || rc(rsp_data) !== 32'h2345_6789) begin errors++; $display("FAIL b2b_data0 got %h want 23456789", rc(rsp_data)); end
        rsp_ready = 2'b10;
        for (int c = 0; c < 20; c++) begin
            step();
            if (rsp_valid !== 2'b01 || rsp_data !== snap || req_ready !== 2'b00 || alu_enable !== 1'b0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL b2b_hold got %0d bad cycles want 0", viol); end
        rsp_ready = 2'b00;
        ack(0);
        wait_grant(g, ok);
        req_valid = 2'b00;
        checks++; if (!ok || g != 1) begin errors++; $display("FAIL b2b_grant1 got %0d want 1", g); end
        wait_rsp(100, lat, ok);
        checks++; if (!ok || rc(rsp_data) !== 32'h0 || rsp_carry !== 1'b1) begin errors++; $display("FAIL b2b_data1 got %h c%b want 0 c1", rc(rsp_data), rsp_carry); end
        ack(1);
        checks++; if (gap_err != 0 || stab_err != 0) begin errors++; $display("FAIL b2b_alu_rules got gap %0d stab %0d want 0 0", gap_err, stab_err); end
    endtask

    initial begin
        rst = 1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_cin = '0;
        rsp_ready = '0; rng_valid = 1;
        rng_data = {96'hCAFE0000CAFE0000CAFE0003, 96'hBEEF0000BEEF0000BEEF0002, 96'h0F0F0F0F55AA55AA12345678};
        step();
        test_reset();
        test_single();
        test_rr();
        test_rng_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks %0d", checks);
        $fatal(1);
    end
endmodule
